// File: rtl/mem_package.sv
// Shared types and helpers for the parametrised memory bank.
// FSM state encoding, op codes and byte parity.
package mem_package;

   typedef enum logic {ST_IDLE, ST_CLEAR} mem_state_e;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   function automatic logic parity8(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read response shift register, LAT stages deep.
// Data only advances with valid so the last stage holds its value.
module mem_rd_pipe #(
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          flush_n,
   input  logic          vld_i,
   input  logic          err_i,
   input  logic          par_i,
   input  logic [DW-1:0] data_i,
   output logic          vld_o,
   output logic          err_o,
   output logic          par_o,
   output logic [DW-1:0] data_o
);

   logic [LAT-1:0]         vld_q;
   logic [LAT-1:0]         err_q;
   logic [LAT-1:0]         par_q;
   logic [LAT-1:0][DW-1:0] data_q;

   // Shift the response bundle one stage per cycle; flush clears all.
   always_ff @(posedge clk) begin
      if (!flush_n) begin
         vld_q  <= '0;
         err_q  <= '0;
         par_q  <= '0;
         data_q <= '0;
      end else begin
         vld_q[0] <= vld_i;
         err_q[0] <= err_i;
         par_q[0] <= par_i;
         if (vld_i)
            data_q[0] <= data_i;
         for (int s = 1; s < LAT; s++) begin
            vld_q[s] <= vld_q[s-1];
            err_q[s] <= err_q[s-1];
            par_q[s] <= par_q[s-1];
            if (vld_q[s-1])
               data_q[s] <= data_q[s-1];
         end
      end
   end

   assign vld_o  = vld_q[LAT-1];
   assign err_o  = err_q[LAT-1];
   assign par_o  = par_q[LAT-1];
   assign data_o = data_q[LAT-1];

endmodule

// File: rtl/mem_param_bank.sv
// Single-port memory bank with byte enables, range check and clear FSM.
// Optional byte parity storage enabled by MEM_PARITY_EN.
module mem_param_bank
   import mem_package::*;
#(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 4,
   parameter int                DEPTH    = 16,
   parameter int                RD_LAT   = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic                W_R,
   input  logic [ADDR_W-1:0]   Address,
   input  logic [DATA_W-1:0]   Data_in,
   input  logic [DATA_W/8-1:0] Byte_en,
   input  logic                Clr_req,
   output logic [DATA_W-1:0]   Data_out,
   output logic                valid_out,
   output logic                addr_err,
   output logic                busy,
   output logic                par_err
);

   localparam int NB = DATA_W / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IW-1:0]   LAST  = IW'(DEPTH - 1);
   localparam logic [ADDR_W:0] DEP_L = (ADDR_W + 1)'(DEPTH);

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_lat_chk
      $error("mem_param_bank: RD_LAT must be 1 or 2");
   end

   mem_state_e        state_q;
   logic [IW-1:0]     ptr_q;
   logic              wr_err_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              acc;
   logic              rd_acc;
   logic              wr_acc;
   logic              in_rng;
   logic              clr_we;
   logic [IW-1:0]     idx;
   logic [DATA_W-1:0] rd_word;
   logic              rd_par;
   logic              p_err;

   assign busy    = (state_q == ST_CLEAR);
   assign acc     = EN & ~busy & RST & ~Clr_req;
   assign rd_acc  = acc & (W_R == OP_READ);
   assign wr_acc  = acc & (W_R == OP_WRITE);
   assign in_rng  = {1'b0, Address} < DEP_L;
   assign clr_we  = busy & RST;
   assign idx     = Address[IW-1:0];
   assign rd_word = in_rng ? mem_q[idx] : '0;

   // Array update: clear sweep or byte-masked write, never both.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem_q[ptr_q] <= INIT_VAL;
      end else if (wr_acc && in_rng) begin
         for (int b = 0; b < NB; b++)
            if (Byte_en[b])
               mem_q[idx][8*b +: 8] <= Data_in[8*b +: 8];
      end
   end

`ifdef MEM_PARITY_EN
   logic [NB-1:0] pmem_q [DEPTH];

   // Parity bits follow the same write/clear path as the data.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         for (int b = 0; b < NB; b++)
            pmem_q[ptr_q][b] <= parity8(INIT_VAL[8*b +: 8]);
      end else if (wr_acc && in_rng) begin
         for (int b = 0; b < NB; b++)
            if (Byte_en[b])
               pmem_q[idx][b] <= parity8(Data_in[8*b +: 8]);
      end
   end

   // Flag any byte whose recomputed parity disagrees with storage.
   always_comb begin
      rd_par = 1'b0;
      if (rd_acc && in_rng)
         for (int b = 0; b < NB; b++)
            if (parity8(rd_word[8*b +: 8]) != pmem_q[idx][b])
               rd_par = 1'b1;
   end
`else
   assign rd_par = 1'b0;
`endif

   // Clear FSM: sweep pointer over every word, then back to idle.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (Clr_req) begin
                  state_q <= ST_CLEAR;
                  ptr_q   <= '0;
               end
            end
            ST_CLEAR: begin
               if (ptr_q == LAST) begin
                  state_q <= ST_IDLE;
                  ptr_q   <= '0;
               end else begin
                  ptr_q <= ptr_q + 1'b1;
               end
            end
         endcase
      end
   end

   // Out-of-range write error is a one-cycle pulse after acceptance.
   always_ff @(posedge CLK) begin
      if (!RST)
         wr_err_q <= 1'b0;
      else
         wr_err_q <= wr_acc & ~in_rng;
   end

   mem_rd_pipe #(
      .DW  (DATA_W),
      .LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (CLK),
      .flush_n (RST),
      .vld_i   (rd_acc),
      .err_i   (rd_acc & ~in_rng),
      .par_i   (rd_par),
      .data_i  (rd_word),
      .vld_o   (valid_out),
      .err_o   (p_err),
      .par_o   (par_err),
      .data_o  (Data_out)
   );

   assign addr_err = p_err | wr_err_q;

endmodule
